// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory: FSM encoding and address-geometry helpers.
package dmem_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ofs_bits(input int data_w);
        return clog2(data_w / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return clog2(depth);
    endfunction

    // Geometry of the default 32-bit x 1024-word configuration.
    localparam int OFS   = ofs_bits(32);
    localparam int IDX_W = idx_bits(1024);

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W RAM: synchronous byte-enable write, registered read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Power-up contents are zero; reset never touches the array.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[rd_idx];
    end

endmodule

// File: rtl/data_memory_ws.sv
// Single-port data memory with a counted wait-state latency, req/ready handshake,
// byte-enable writes and misalignment / out-of-range fault reporting.
module data_memory_ws
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 32,
    parameter int MEM_DELAY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy,
    output logic                err
);

    localparam int BE_W     = DATA_W / 8;
    localparam int WORD_OFS = ofs_bits(DATA_W);
    localparam int IDX_BITS = idx_bits(DEPTH);
    localparam int CNT_W    = $clog2(MEM_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_DELAY - 1);

    state_t state, state_next;

    logic [CNT_W-1:0]    cnt;
    logic                we_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [DATA_W-1:0]   wdata_p0;
    logic [BE_W-1:0]     be_p0;
    logic                accept;
    logic                done;
    logic                fault;
    logic                wr_en;
    logic [IDX_BITS-1:0] idx_p0;
    logic [IDX_BITS-1:0] rd_idx;
    logic [DATA_W-1:0]   ram_q;

    assign busy   = (state == S_WAIT);
    assign accept = (state == S_IDLE) && req;
    assign done   = (state == S_WAIT) && (cnt == '0);
    assign idx_p0 = addr_p0[WORD_OFS +: IDX_BITS];
    assign fault  = (addr_p0[WORD_OFS-1:0] != '0)
                 || ((addr_p0 >> (WORD_OFS + IDX_BITS)) != '0);
    assign wr_en  = done && we_p0 && !fault;

    // The array read is registered, so address it from the live request while idle
    // (covers MEM_DELAY=1) and from the latched copy while waiting.
    assign rd_idx = (state == S_IDLE) ? addr[WORD_OFS +: IDX_BITS] : idx_p0;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req) state_next = S_WAIT;
            S_WAIT:  if (cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_next;
            ready <= done;
            err   <= done && fault;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (done) begin
                if (fault)       rdata <= '0;
                else if (!we_p0) rdata <= ram_q;
            end
        end
    end

    // Request capture stage: inputs are ignored after acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= we;
            addr_p0  <= addr;
            wdata_p0 <= wdata;
            be_p0    <= be;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_BITS)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .be     (be_p0),
        .wr_idx (idx_p0),
        .wdata  (wdata_p0),
        .rd_idx (rd_idx),
        .rdata  (ram_q)
    );

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: default 32-bit/MEM_DELAY=3 instance plus 64-bit
// instances with MEM_DELAY 1, 2 and 5.
module tb_data_memory_ws;

    localparam int NW = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        ready, busy, err;

    logic        req_w   [NW];
    logic        we_w    [NW];
    logic [31:0] addr_w  [NW];
    logic [63:0] wdata_w [NW];
    logic [7:0]  be_w    [NW];
    logic [63:0] rdata_w [NW];
    logic        ready_w [NW];
    logic        busy_w  [NW];
    logic        err_w   [NW];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_ws #(
        .DATA_W(32), .DEPTH(1024), .ADDR_W(32), .MEM_DELAY(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    for (genvar g = 0; g < NW; g++) begin : g_wide
        data_memory_ws #(
            .DATA_W(64), .DEPTH(256), .ADDR_W(32),
            .MEM_DELAY((g == 0) ? 1 : (g == 1) ? 2 : 5)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .req(req_w[g]), .we(we_w[g]), .addr(addr_w[g]),
            .wdata(wdata_w[g]), .be(be_w[g]), .rdata(rdata_w[g]), .ready(ready_w[g]),
            .busy(busy_w[g]), .err(err_w[g])
        );
    end

    function automatic int exp_dly(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output int lat, output logic [31:0] rd,
                          output logic er, output int busy_cnt);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        // Scramble the inputs after acceptance; only the latched copy may matter.
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = ~d; be = 4'hF;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
        rd = rdata;
        er = err;
    endtask

    task automatic access_w(input int k, input logic w, input logic [31:0] a,
                            input logic [63:0] d, input logic [7:0] b,
                            output int lat, output logic [63:0] rd, output logic er);
        @(negedge clk);
        req_w[k] = 1'b1; we_w[k] = w; addr_w[k] = a; wdata_w[k] = d; be_w[k] = b;
        @(posedge clk); #1;
        req_w[k] = 1'b0; wdata_w[k] = '0; be_w[k] = '0;
        lat = 0;
        while (!ready_w[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_w[k];
        er = err_w[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bc, n_rdy;
        logic [31:0] rd;
        logic [63:0] rdw;
        logic        er, prev_busy;
        logic [9:0]  acc_mask;

        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        for (int k = 0; k < NW; k++) begin
            req_w[k] = 1'b0; we_w[k] = 1'b0; addr_w[k] = '0; wdata_w[k] = '0; be_w[k] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy",  busy,  0);
        check("rst_err",   err,   0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read latency
        access(1'b0, 32'h14, 32'h0, 4'h0, lat, rd, er, bc);
        check("t1_lat",   lat, 3);
        check("t1_busy",  bc,  3);
        check("t1_rdata", rd,  0);
        check("t1_err",   er,  0);
        @(posedge clk); #1;
        check("t1_ready_pulse", ready, 0);

        // Full and partial byte-enable writes
        access(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, lat, rd, er, bc);
        check("t2_wr_lat", lat, 3);
        check("t2_wr_err", er,  0);
        access(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er, bc);
        check("t2_rd_full", rd, 32'hDEAD_BEEF);
        access(1'b1, 32'h40, 32'h1122_3344, 4'b0101, lat, rd, er, bc);
        check("t2_wr_rdata_hold", rd, 32'hDEAD_BEEF);
        access(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er, bc);
        check("t2_rd_partial", rd, 32'hDE22_BE44);

        // Back-to-back requests: only one acceptance per MEM_DELAY+1 cycles
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'h0;
        acc_mask = '0;
        n_rdy = 0;
        for (int c = 0; c < 10; c++) begin
            prev_busy = busy;
            @(negedge clk);
            if (!prev_busy && busy) acc_mask[c] = 1'b1;
            if (ready) n_rdy++;
        end
        req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ready) n_rdy++;
        end
        check("t3_accept_cycles", acc_mask, 10'b01_0001_0001);
        check("t3_ready_count",   n_rdy,    3);

        // Faults: misaligned read, out-of-range write
        access(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er, bc);
        check("t4_pre_rdata", rd, 32'hDE22_BE44);
        access(1'b0, 32'h42, 32'h0, 4'h0, lat, rd, er, bc);
        check("t4_mis_lat",   lat, 3);
        check("t4_mis_err",   er,  1);
        check("t4_mis_rdata", rd,  0);
        access(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, lat, rd, er, bc);
        check("t4_oor_err",   er, 1);
        check("t4_oor_rdata", rd, 0);
        access(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er, bc);
        check("t4_word0",     rd, 0);
        check("t4_word0_err", er, 0);

        // Reset one cycle before a write completes
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hCAFE_F00D; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_busy", busy, 0);
        n_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ready) n_rdy++;
        end
        check("t5_no_ready",   n_rdy, 0);
        check("t5_rst_rdata",  rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 32'h8, 32'h0, 4'h0, lat, rd, er, bc);
        check("t5_aborted_word", rd, 0);
        access(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er, bc);
        check("t5_survivor", rd, 32'hDE22_BE44);

        // 64-bit instances with different latencies
        for (int k = 0; k < NW; k++) begin
            access_w(k, 1'b1, 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rdw, er);
            check($sformatf("w%0d_wr_lat", k), lat, exp_dly(k));
            check($sformatf("w%0d_wr_err", k), er, 0);
            access_w(k, 1'b0, 32'h10, 64'h0, 8'h00, lat, rdw, er);
            check($sformatf("w%0d_rd_lat", k), lat, exp_dly(k));
            check($sformatf("w%0d_rd_full", k), rdw, 64'h0123_4567_89AB_CDEF);
            access_w(k, 1'b1, 32'h10, 64'hFFEE_DDCC_BBAA_9988, 8'b1010_0101, lat, rdw, er);
            access_w(k, 0, 32'h10, 64'h0, 8'h00, lat, rdw, er);
            check($sformatf("w%0d_rd_partial", k), rdw, 64'hFF23_DD67_89AA_CD88);
            check($sformatf("w%0d_busy_after", k), busy_w[k], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
